// File: rtl/truth_table_scanner_if.sv
// ----------------------------------------------------------------------------
// truth_table_scanner_if
// Control/result bundle between the board-level start/compare logic (master)
// and the truth-table scanner (slave).
//   start      scan request, honoured only while the scanner is idle
//   expected   reference truth table, bit i = expected f for {x,y,z} = i
//   busy       scan in progress
//   done       one-cycle pulse, results valid
//   table_out  captured truth table, bit i = f sampled for vector i
//   pass       table_out matches the latched reference
//   err_count  number of mismatching table bits, 0..8
// ----------------------------------------------------------------------------
interface truth_table_scanner_if;
    logic       start;
    logic [7:0] expected;
    logic       busy;
    logic       done;
    logic [7:0] table_out;
    logic       pass;
    logic [3:0] err_count;

    modport master (
        output start, expected,
        input  busy, done, table_out, pass, err_count
    );

    modport slave (
        input  start, expected,
        output busy, done, table_out, pass, err_count
    );
endinterface

// File: rtl/truth_table_scanner.sv
// ----------------------------------------------------------------------------
// truth_table_scanner
// Drives a 3-input combinational function through all 8 input vectors,
// samples its output SETTLE cycles after each vector is presented, builds
// the 8-bit truth table and compares it with a reference latched at start.
//   SETTLE  cycles between presenting a vector and sampling f_in (1..15)
//   clk     system clock, rising edge
//   rst_n   synchronous active-low reset
//   bus     control/result bundle (slave side)
//   f_in    output of the function under test
//   x_out   vector MSB to the function under test
//   y_out   vector middle bit
//   z_out   vector LSB
// ----------------------------------------------------------------------------
module truth_table_scanner #(
    parameter int unsigned SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    truth_table_scanner_if.slave   bus,
    input  logic                   f_in,
    output logic                   x_out,
    output logic                   y_out,
    output logic                   z_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SAMPLE,
        ST_FINISH
    } state_t;

    // Counter runs SETTLE-1 .. 0 in WAIT, giving exactly SETTLE WAIT cycles.
    localparam logic [3:0] LP_RELOAD = 4'(SETTLE - 1);

    state_t     r_state;
    logic [2:0] r_idx;
    logic [3:0] r_cnt;
    logic [7:0] r_exp;
    logic [7:0] r_table;
    logic [3:0] r_err_acc;
    logic [3:0] r_err_count;
    logic       r_pass;
    logic       r_busy;
    logic       r_done;

    logic [7:0] w_table_next;
    logic       w_mismatch;
    logic [3:0] w_err_next;

    // Table and error tally including the bit being sampled this cycle, so the
    // final pass/err_count are ready in the same edge that raises done.
    always_comb begin
        w_table_next        = r_table;
        w_table_next[r_idx] = f_in;
        w_mismatch          = f_in ^ r_exp[r_idx];
        w_err_next          = r_err_acc + {3'b000, w_mismatch};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_exp       <= '0;
            r_table     <= '0;
            r_err_acc   <= '0;
            r_err_count <= '0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_exp       <= bus.expected;
                        r_table     <= '0;
                        r_pass      <= 1'b0;
                        r_err_count <= '0;
                        r_err_acc   <= '0;
                        r_idx       <= '0;
                        r_cnt       <= LP_RELOAD;
                        r_busy      <= 1'b1;
                        r_state     <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                ST_SAMPLE: begin
                    r_table   <= w_table_next;
                    r_err_acc <= w_err_next;
                    if (r_idx == 3'd7) begin
                        r_err_count <= w_err_next;
                        r_pass      <= (w_err_next == 4'd0);
                        r_done      <= 1'b1;
                        // Vector returns to 000 as it leaves the last SAMPLE.
                        r_idx       <= '0;
                        r_state     <= ST_FINISH;
                    end else begin
                        r_idx   <= r_idx + 3'd1;
                        r_cnt   <= LP_RELOAD;
                        r_state <= ST_WAIT;
                    end
                end

                ST_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // The vector outputs are the registered index itself; it is 0 whenever
    // the scanner is idle.
    assign x_out         = r_idx[2];
    assign y_out         = r_idx[1];
    assign z_out         = r_idx[0];

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.table_out = r_table;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_truth_table_scanner.sv
// ----------------------------------------------------------------------------
// tb_truth_table_scanner
// Directed bench: instance A (SETTLE=1) scans f = xy' + y'z + xz + xyz',
// instance B (SETTLE=3) scans a function tied to 0.
// ----------------------------------------------------------------------------
module tb_truth_table_scanner;

    logic clk;
    logic rst_n;
    logic w_xa, w_ya, w_za, w_fa;
    logic w_xb, w_yb, w_zb;
    logic w_fb;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    truth_table_scanner_if ifa ();
    truth_table_scanner_if ifb ();

    assign w_fa = (w_xa & ~w_ya) | (~w_ya & w_za) | (w_xa & w_za) | (w_xa & w_ya & ~w_za);
    assign w_fb = 1'b0;

    truth_table_scanner #(.SETTLE(1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa),
        .f_in  (w_fa),
        .x_out (w_xa),
        .y_out (w_ya),
        .z_out (w_za)
    );

    truth_table_scanner #(.SETTLE(3)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb),
        .f_in  (w_fb),
        .x_out (w_xb),
        .y_out (w_yb),
        .z_out (w_zb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic done_of(input bit use_b);
        return use_b ? ifb.done : ifa.done;
    endfunction

    function automatic logic [2:0] vec_of(input bit use_b);
        return use_b ? {w_xb, w_yb, w_zb} : {w_xa, w_ya, w_za};
    endfunction

    // Called with c0 cycles already elapsed since the accepting edge; checks
    // the presented vector every cycle and the total start-to-done latency.
    task automatic run_to_done(input bit use_b, input int unsigned settle,
                               input int unsigned c0, input string tag);
        int unsigned c = c0;
        while (!done_of(use_b) && c < 300) begin
            check({tag, " vec"}, {29'd0, vec_of(use_b)}, (c / (settle + 1)) & 7);
            tick();
            c++;
        end
        check({tag, " latency"}, c, 8 * (settle + 1));
        check({tag, " busy@done"}, use_b ? ifb.busy : ifa.busy, 1);
    endtask

    initial begin
        rst_n        = 1'b0;
        ifa.start    = 1'b0;
        ifa.expected = 8'h00;
        ifb.start    = 1'b0;
        ifb.expected = 8'h00;

        // Reset state
        tick();
        tick();
        check("rst busy", ifa.busy, 0);
        check("rst done", ifa.done, 0);
        check("rst table", ifa.table_out, 8'h00);
        check("rst pass", ifa.pass, 0);
        check("rst err", ifa.err_count, 0);
        check("rst vec", {29'd0, w_xa, w_ya, w_za}, 0);
        rst_n = 1'b1;
        tick();

        // Golden scan, matching reference
        ifa.start    = 1'b1;
        ifa.expected = 8'hF2;
        tick();
        ifa.start = 1'b0;
        check("s1 busy", ifa.busy, 1);
        run_to_done(1'b0, 1, 0, "s1");
        check("s1 table", ifa.table_out, 8'hF2);
        check("s1 pass", ifa.pass, 1);
        check("s1 err", ifa.err_count, 0);

        // Results held after done
        tick();
        tick();
        tick();
        check("hold done", ifa.done, 0);
        check("hold busy", ifa.busy, 0);
        check("hold table", ifa.table_out, 8'hF2);
        check("hold pass", ifa.pass, 1);
        check("hold vec", {29'd0, w_xa, w_ya, w_za}, 0);

        // All-mismatch reference; restart attempt and new reference mid-scan
        ifa.start    = 1'b1;
        ifa.expected = 8'h0D;
        tick();
        ifa.start = 1'b0;
        check("s2 clr table", ifa.table_out, 8'h00);
        repeat (4) tick();
        ifa.start    = 1'b1;
        ifa.expected = 8'h00;
        tick();
        ifa.start = 1'b0;
        run_to_done(1'b0, 1, 5, "s2");
        check("s2 table", ifa.table_out, 8'hF2);
        check("s2 pass", ifa.pass, 0);
        check("s2 err", ifa.err_count, 8);
        tick();

        // Reset in the middle of a scan
        ifa.start    = 1'b1;
        ifa.expected = 8'hF2;
        tick();
        ifa.start = 1'b0;
        repeat (5) tick();
        check("mid vec", {29'd0, w_xa, w_ya, w_za}, 2);
        check("mid table", ifa.table_out, 8'h02);
        rst_n = 1'b0;
        tick();
        check("mr1 done", ifa.done, 0);
        check("mr1 busy", ifa.busy, 0);
        tick();
        check("mr2 done", ifa.done, 0);
        check("mr2 busy", ifa.busy, 0);
        check("mr2 table", ifa.table_out, 8'h00);
        check("mr2 vec", {29'd0, w_xa, w_ya, w_za}, 0);
        rst_n        = 1'b1;
        ifa.start    = 1'b1;
        tick();
        ifa.start = 1'b0;
        check("s3 busy", ifa.busy, 1);
        run_to_done(1'b0, 1, 0, "s3");
        check("s3 table", ifa.table_out, 8'hF2);
        check("s3 pass", ifa.pass, 1);
        check("s3 err", ifa.err_count, 0);
        tick();

        // start held through two scans
        ifa.start    = 1'b1;
        ifa.expected = 8'hF2;
        tick();
        run_to_done(1'b0, 1, 0, "h1");
        check("h1 table", ifa.table_out, 8'hF2);
        tick();
        check("h gap busy", ifa.busy, 0);
        check("h gap done", ifa.done, 0);
        check("h gap table", ifa.table_out, 8'hF2);
        check("h gap pass", ifa.pass, 1);
        tick();
        check("h2 busy", ifa.busy, 1);
        check("h2 clr table", ifa.table_out, 8'h00);
        run_to_done(1'b0, 1, 0, "h2");
        ifa.start = 1'b0;
        check("h2 table", ifa.table_out, 8'hF2);
        check("h2 pass", ifa.pass, 1);
        tick();

        // SETTLE=3, constant-0 function
        ifb.start    = 1'b1;
        ifb.expected = 8'h81;
        tick();
        ifb.start = 1'b0;
        check("b busy", ifb.busy, 1);
        run_to_done(1'b1, 3, 0, "b");
        check("b table", ifb.table_out, 8'h00);
        check("b pass", ifb.pass, 0);
        check("b err", ifb.err_count, 2);
        tick();
        check("b end busy", ifb.busy, 0);
        check("a idle busy", ifa.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
